// File: rtl/control_sequencer.sv
// control_sequencer: FETCH / EXEC1 / EXEC2 / HALT phase sequencer with an
// instruction register and a set_jump delay line. It also has optional
// saturating performance counters. The counters are enabled by defining
// SEQ_PERF_COUNTERS_EN.
module control_sequencer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] instr_in,
   input  logic        sm_extra,
   input  logic        stop,
   input  logic        set_jump,
   input  logic        run,
`ifdef SEQ_PERF_COUNTERS_EN
   input  logic        cnt_clr,
   output logic [15:0] instr_count,
   output logic [15:0] cycle_count,
`endif
   output logic [15:0] instruction,
   output logic [1:0]  state,
   output logic        jump,
   output logic        two_cycles_after_jump,
   output logic        halted
);

   typedef enum logic [1:0] {
      FETCH = 2'b00,
      EXEC1 = 2'b01,
      EXEC2 = 2'b10,
      HALT  = 2'b11
   } phase_t;

   phase_t phase;
   phase_t phase_nxt;

   assign state = phase;

   // Next phase: stop has priority over every other transition.
   always_comb begin
      phase_nxt = phase;
      if (stop) begin
         phase_nxt = HALT;
      end else begin
         case (phase)
            FETCH: phase_nxt = EXEC1;
            EXEC1: phase_nxt = sm_extra ? EXEC2 : FETCH;
            EXEC2: phase_nxt = FETCH;
            HALT:  phase_nxt = run ? FETCH : HALT;
         endcase
      end
   end

   // Phase register, IR load on FETCH exit, halted flag and jump delay line.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         phase                 <= FETCH;
         instruction           <= '0;
         jump                  <= 1'b0;
         two_cycles_after_jump <= 1'b0;
         halted                <= 1'b0;
      end else begin
         phase                 <= phase_nxt;
         halted                <= (phase_nxt == HALT);
         jump                  <= set_jump;
         two_cycles_after_jump <= jump;
         if (phase == FETCH && phase_nxt == EXEC1) begin
            instruction <= instr_in;
         end
      end
   end

`ifdef SEQ_PERF_COUNTERS_EN
   logic retire;

   // An instruction retires only when an execute phase returns to FETCH.
   // A move into HALT is not a retirement.
   assign retire = ((phase == EXEC1) || (phase == EXEC2)) && (phase_nxt == FETCH);

   // Saturating counters. A clear takes priority over any increment.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         instr_count <= '0;
         cycle_count <= '0;
      end else if (cnt_clr) begin
         instr_count <= '0;
         cycle_count <= '0;
      end else begin
         if (retire && instr_count != '1) begin
            instr_count <= instr_count + 16'd1;
         end
         if (phase != HALT && cycle_count != '1) begin
            cycle_count <= cycle_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed stimulus for control_sequencer.
// An instruction-level model runs inside the bench and is compared with the
// DUT on every cycle. Literal expectations at key points pin the model itself.
// The counter checks exist only when SEQ_PERF_COUNTERS_EN is defined.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] instr_in;
   logic        sm_extra;
   logic        stop;
   logic        set_jump;
   logic        run;
   logic        cnt_clr;
   logic [15:0] instruction;
   logic [1:0]  state;
   logic        jump;
   logic        two_cycles_after_jump;
   logic        halted;
`ifdef SEQ_PERF_COUNTERS_EN
   logic [15:0] instr_count;
   logic [15:0] cycle_count;
`endif

   int checks = 0;
   int errors = 0;

   control_sequencer dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .instr_in              (instr_in),
      .sm_extra              (sm_extra),
      .stop                  (stop),
      .set_jump              (set_jump),
      .run                   (run),
`ifdef SEQ_PERF_COUNTERS_EN
      .cnt_clr               (cnt_clr),
      .instr_count           (instr_count),
      .cycle_count           (cycle_count),
`endif
      .instruction           (instruction),
      .state                 (state),
      .jump                  (jump),
      .two_cycles_after_jump (two_cycles_after_jump),
      .halted                (halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction-level model: halted flag, position within the current
   // instruction (0 = fetch, 1 = first execute, 2 = second execute),
   // the latched instruction, the jump history and the counters as integers.
   bit          model_ok = 1'b0;
   bit          m_halt;
   int          m_pos;
   logic [15:0] m_ir;
   bit          m_j1, m_j2;
   int          m_ic, m_cc;

   always @(posedge clk) begin
      bit active;
      bit retired;
      if (!reset_n) begin
         m_halt = 0; m_pos = 0; m_ir = '0; m_j1 = 0; m_j2 = 0;
         m_ic = 0; m_cc = 0; model_ok = 1'b1;
      end else begin
         active  = !m_halt;
         retired = 0;
         m_j2 = m_j1;
         m_j1 = set_jump;
         if (stop) begin
            m_halt = 1;
         end else if (m_halt) begin
            if (run) begin
               m_halt = 0;
               m_pos  = 0;
            end
         end else if (m_pos == 0) begin
            m_ir  = instr_in;
            m_pos = 1;
         end else if (m_pos == 1 && sm_extra) begin
            m_pos = 2;
         end else begin
            m_pos   = 0;
            retired = 1;
         end
         if (cnt_clr) begin
            m_ic = 0;
            m_cc = 0;
         end else begin
            if (retired && m_ic < 65535) m_ic++;
            if (active && m_cc < 65535) m_cc++;
         end
      end
   end

   // Every-cycle comparison on the falling edge.
   always @(negedge clk) begin
      if (model_ok) begin
         check("state", 32'(state), m_halt ? 32'd3 : 32'(m_pos));
         check("halted", 32'(halted), 32'(m_halt));
         check("instruction", 32'(instruction), 32'(m_ir));
         check("jump", 32'(jump), 32'(m_j1));
         check("two_cycles_after_jump", 32'(two_cycles_after_jump), 32'(m_j2));
`ifdef SEQ_PERF_COUNTERS_EN
         check("instr_count", 32'(instr_count), 32'(m_ic));
         check("cycle_count", 32'(cycle_count), 32'(m_cc));
`endif
      end
   end

   // Drive one cycle of inputs, then return just after the next rising edge.
   task automatic cyc(input logic rn, input logic [15:0] ins, input logic se,
                      input logic st, input logic sj, input logic rr, input logic cc);
      reset_n = rn; instr_in = ins; sm_extra = se; stop = st;
      set_jump = sj; run = rr; cnt_clr = cc;
      @(posedge clk);
      #1;
   endtask

   task automatic lit_counts(input string tag, input int ic, input int cc);
`ifdef SEQ_PERF_COUNTERS_EN
      check({tag, "_instr_count"}, 32'(instr_count), 32'(ic));
      check({tag, "_cycle_count"}, 32'(cycle_count), 32'(cc));
`else
      if (ic < 0 || cc < 0) $display("bad literal for %s", tag);
`endif
   endtask

   initial begin
      // Reset overrides stop/run/cnt_clr.
      cyc(0, 16'hFFFF, 1, 1, 1, 1, 1);
      cyc(0, 16'hFFFF, 1, 1, 1, 1, 1);
      check("rst_state", 32'(state), 32'd0);
      check("rst_ir", 32'(instruction), 32'h0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_jump", 32'(jump), 32'd0);
      lit_counts("rst", 0, 0);

      // Two-cycle ADD instructions back to back.
      cyc(1, 16'h4019, 0, 0, 0, 0, 0);
      check("add_state1", 32'(state), 32'd1);
      check("add_ir", 32'(instruction), 32'h4019);
      cyc(1, 16'h4019, 0, 0, 0, 0, 0);
      check("add_state2", 32'(state), 32'd0);
      cyc(1, 16'h4019, 0, 0, 0, 0, 0);
      check("add_state3", 32'(state), 32'd1);
      cyc(1, 16'h4019, 0, 0, 0, 0, 0);
      check("add_state4", 32'(state), 32'd0);
      lit_counts("add", 2, 4);

      // Clear on a retirement edge, then a three-cycle LDI. sm_extra is
      // held high in FETCH and EXEC2, where it must have no effect.
      cyc(1, 16'h4019, 0, 0, 0, 0, 0);
      cyc(1, 16'h4019, 0, 0, 0, 0, 1);
      lit_counts("clr", 0, 0);
      cyc(1, 16'h0500, 1, 0, 0, 0, 0);
      check("ldi_state1", 32'(state), 32'd1);
      check("ldi_ir", 32'(instruction), 32'h0500);
      cyc(1, 16'h0500, 1, 0, 0, 0, 0);
      check("ldi_state2", 32'(state), 32'd2);
      cyc(1, 16'h0500, 1, 0, 0, 0, 0);
      check("ldi_state3", 32'(state), 32'd0);
      lit_counts("ldi", 1, 3);

      // set_jump pulse in EXEC1. run must be ignored outside HALT.
      cyc(1, 16'h4019, 0, 0, 0, 1, 0);
      check("run_ignored", 32'(state), 32'd1);
      cyc(1, 16'h4019, 0, 0, 1, 0, 0);
      check("jmp_d1", 32'(jump), 32'd1);
      check("jmp_d1_2c", 32'(two_cycles_after_jump), 32'd0);
      cyc(1, 16'h4019, 0, 0, 0, 0, 0);
      check("jmp_d2", 32'(jump), 32'd0);
      check("jmp_d2_2c", 32'(two_cycles_after_jump), 32'd1);
      cyc(1, 16'h4019, 0, 0, 0, 0, 0);
      check("jmp_d3_2c", 32'(two_cycles_after_jump), 32'd0);
      lit_counts("jmp", 3, 7);

      // stop in EXEC1 moves to HALT. Everything is frozen for 10 cycles, then run.
      cyc(1, 16'h1234, 0, 0, 0, 0, 0);
      cyc(1, 16'h1234, 0, 1, 0, 0, 0);
      check("halt_state", 32'(state), 32'd3);
      check("halt_flag", 32'(halted), 32'd1);
      lit_counts("halt", 3, 9);
      for (int i = 0; i < 10; i++) begin
         cyc(1, 16'hA5A5 ^ 16'(i), 1, 0, (i == 3), 0, 0);
      end
      check("halt_ir_frozen", 32'(instruction), 32'h1234);
      check("halt_still", 32'(halted), 32'd1);
      lit_counts("halt10", 3, 9);
      cyc(1, 16'h4019, 0, 0, 0, 1, 0);
      check("resume_state", 32'(state), 32'd0);
      check("resume_halted", 32'(halted), 32'd0);
      lit_counts("resume", 3, 9);

      // stop in FETCH must not load the IR. stop beats run in HALT.
      cyc(1, 16'hBEEF, 0, 1, 0, 0, 0);
      check("stopf_ir", 32'(instruction), 32'h1234);
      check("stopf_state", 32'(state), 32'd3);
      cyc(1, 16'hBEEF, 0, 1, 0, 1, 0);
      check("stop_over_run", 32'(state), 32'd3);
      cyc(1, 16'hBEEF, 0, 0, 0, 1, 0);
      check("resume2_state", 32'(state), 32'd0);

      // Reset in the middle of EXEC2 with cycle_count at 5.
      cyc(1, 16'h0500, 0, 0, 0, 0, 1);
      cyc(1, 16'h0500, 0, 0, 0, 0, 0);
      cyc(1, 16'h0500, 0, 0, 0, 0, 0);
      cyc(1, 16'h0500, 0, 0, 0, 0, 0);
      cyc(1, 16'h0500, 0, 0, 0, 0, 0);
      cyc(1, 16'h0500, 1, 0, 0, 0, 0);
      check("pre_rst_state", 32'(state), 32'd2);
      lit_counts("pre_rst", 2, 5);
      cyc(0, 16'h0500, 1, 1, 1, 1, 1);
      check("mid_rst_state", 32'(state), 32'd0);
      check("mid_rst_ir", 32'(instruction), 32'h0);
      check("mid_rst_jump", 32'(jump), 32'd0);
      lit_counts("mid_rst", 0, 0);

      // Reset while in HALT.
      cyc(1, 16'h4019, 0, 1, 0, 0, 0);
      check("pre_rst_halt", 32'(halted), 32'd1);
      cyc(0, 16'h4019, 0, 0, 0, 0, 0);
      check("halt_rst_state", 32'(state), 32'd0);
      check("halt_rst_halted", 32'(halted), 32'd0);

      // Long run to saturate cycle_count. Then clear on a retirement edge.
      for (int i = 0; i < 65540; i++) begin
         cyc(1, 16'h4019, 0, 0, 0, 0, 0);
      end
      check("long_state", 32'(state), 32'd0);
      lit_counts("sat", 32770, 65535);
      cyc(1, 16'h4019, 0, 0, 0, 0, 0);
      lit_counts("sat_hold", 32770, 65535);
      cyc(1, 16'h4019, 0, 0, 0, 0, 1);
      check("satclr_state", 32'(state), 32'd0);
      lit_counts("sat_clr", 0, 0);
      cyc(1, 16'h4019, 0, 0, 0, 0, 0);
      cyc(1, 16'h4019, 0, 0, 0, 0, 0);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk (rising edge), reset_n.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 instr_in  input  16  instruction word from instruction RAM at the current PC.
REQ-005 sm_extra  input  1  decoder request for a second execute cycle (EXEC2); sampled in EXEC1 only.
REQ-006 stop  input  1  decoder halt request; sampled in every state.
REQ-007 set_jump  input  1  decoder flag: PC was reloaded this cycle.
REQ-008 run  input  1  restart pulse; effective only in HALT.
REQ-009 cnt_clr  input  1  clears the performance counters (present only with the macro in REQ-030).
REQ-010 instruction  output  16  instruction register (IR) presented to the decoder.
REQ-011 state  output  2  phase code: FETCH=00, EXEC1=01, EXEC2=10, HALT=11.
REQ-012 jump  output  1  set_jump delayed by one cycle.
REQ-013 two_cycles_after_jump  output  1  set_jump delayed by two cycles.
REQ-014 halted  output  1  high while state==HALT.
REQ-015 instr_count  output  16  retired-instruction count (present only with the macro).
REQ-016 cycle_count  output  16  active-cycle count (present only with the macro).

Function
REQ-017 The state transitions SHALL be, evaluated in priority order:
- Any state with stop=1 → HALT.
- FETCH → EXEC1.
- EXEC1 with sm_extra=1 → EXEC2; otherwise → FETCH.
- EXEC2 → FETCH.
- HALT with run=1 and stop=0 → FETCH; otherwise stay in HALT.
REQ-018 IR SHALL load instr_in on the clock edge that leaves FETCH, and SHALL hold its value in all other cycles, including HALT.
REQ-019 IR SHALL NOT load when stop=1 in FETCH; the HALT transition takes priority.
REQ-020 jump SHALL equal set_jump registered once, and two_cycles_after_jump SHALL equal jump registered once; both SHALL update in every state, including HALT.
REQ-021 halted SHALL be a registered copy of (next state == HALT), so it is coincident with state==11.
REQ-022 An instruction SHALL count as retired on any edge that moves EXEC1 → FETCH or EXEC2 → FETCH; a transition into HALT SHALL NOT count as a retirement.
REQ-023 Latency: a 2-cycle instruction occupies FETCH plus EXEC1; a 3-cycle instruction occupies FETCH, EXEC1 and EXEC2; after run, the next FETCH is 1 cycle later.
REQ-024 sm_extra SHALL be ignored in FETCH, EXEC2 and HALT.
REQ-025 run SHALL be ignored outside HALT.

Reset
REQ-026 When reset_n=0 at a clock edge, the block SHALL set state=FETCH, instruction=16'h0000, jump=0, two_cycles_after_jump=0, halted=0, and both counters to 0.
REQ-027 Reset SHALL override stop, run, cnt_clr and every in-flight phase, including mid-EXEC2 and HALT.
REQ-028 The first IR load after reset SHALL occur on the first edge with reset_n=1.

Configuration
REQ-029 Exactly one compile-time option SHALL be provided, for the performance counters.
REQ-030 When SEQ_PERF_COUNTERS_EN is defined, the block SHALL include the following:
- instr_count increments by 1 per retirement (REQ-022).
- cycle_count increments by 1 on every edge where state != HALT.
- Both counters saturate at 16'hFFFF.
- cnt_clr=1 zeros both counters on the next edge and takes priority over any increment that edge.
REQ-031 When SEQ_PERF_COUNTERS_EN is undefined, the ports cnt_clr, instr_count and cycle_count SHALL be absent, no counter logic SHALL be generated, and all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then release with instr_in=16'h4019 (2-cycle ADD) and sm_extra=0 → state sequence 00,01,00,01; instruction=16'h4019 from the second cycle onward; instr_count=2 after 4 cycles.
REQ-033 instr_in=16'h0500 (LDI), sm_extra=1 in EXEC1 → state sequence 00,01,10,00; one retirement; cycle_count=3.
REQ-034 set_jump pulsed for one cycle in EXEC1 → jump=1 exactly one cycle later and two_cycles_after_jump=1 exactly two cycles later, each for one cycle.
REQ-035 stop=1 in EXEC1 → HALT next cycle and halted=1; IR and counters frozen for 10 cycles; run=1 → FETCH next cycle; no retirement counted for the halted instruction.
REQ-036 reset_n=0 during EXEC2 with the counters at 16'h0005 → next cycle state=00, IR=0, counters=0.
REQ-037 With the counters preloaded to 16'hFFFF by long run and cnt_clr=1 in the same cycle as a retirement → counters=0 next cycle; without cnt_clr, counters hold at 16'hFFFF.
